// File: rtl/button_debounce_bank_pkg.sv
// button_debounce_bank_pkg: board timing constants shared by the board top and the debounce bank.
package button_debounce_bank_pkg;
   localparam int CLK_HZ            = 16_000_000;
   localparam int DEBOUNCE_MS       = 1;
   localparam int DEBOUNCE_CYC_DFLT = CLK_HZ / 1000 * DEBOUNCE_MS;
endpackage

// File: rtl/button_debounce_bank_channel.sv
// debounce_channel: one button -- two-flop synchroniser, stability counter, level and press/release pulses.
module debounce_channel
   import button_debounce_bank_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DFLT,
   parameter int CNT_W        = 16,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_press_nxt
);
   localparam logic             P_INACT = (ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0] P_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
   logic             r_sync1, r_sync2, r_level, r_press, r_release;
   logic [CNT_W-1:0] r_cnt;
   logic             w_log, w_diff, w_take;
   assign w_log       = r_sync2 ^ P_INACT;
   assign w_diff      = w_log != r_level;
   assign w_take      = w_diff && (r_cnt == P_LAST);
   assign o_press_nxt = w_take & w_log;
   assign o_level     = r_level;
   assign o_press     = r_press;
   assign o_release   = r_release;
   // a bounce back to the accepted level clears the count, so only a continuous run is accepted
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1   <= P_INACT;
         r_sync2   <= P_INACT;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_sync1   <= i_raw;
         r_sync2   <= r_sync1;
         r_cnt     <= (w_diff && !w_take) ? r_cnt + CNT_W'(1) : '0;
         r_level   <= w_take ? w_log : r_level;
         r_press   <= w_take & w_log;
         r_release <= w_take & ~w_log;
      end
   end
endmodule

// File: rtl/button_debounce_bank.sv
// button_debounce_bank: N_CH independent debounced pushbuttons with level, press/release pulses and any_press.
module button_debounce_bank
   import button_debounce_bank_pkg::*;
#(
   parameter int N_CH         = 4,
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DFLT,
   parameter int CNT_W        = 16,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_press,
   output logic [N_CH-1:0] btn_release,
   output logic            any_press
);
   logic [N_CH-1:0] w_press_nxt;
   logic            r_any;
   if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > (2**CNT_W) - 1) begin : g_bad_cfg
      $error("button_debounce_bank: DEBOUNCE_CYC out of range for CNT_W");
   end
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .CNT_W        (CNT_W),
         .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_ch (
         .i_clk       (CLK),
         .i_rst_n     (RST_N),
         .i_raw       (btn_raw[i]),
         .o_level     (btn_level[i]),
         .o_press     (btn_press[i]),
         .o_release   (btn_release[i]),
         .o_press_nxt (w_press_nxt[i])
      );
   end
   // registered from the channels' next-press terms so it lines up with btn_press
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_any <= 1'b0;
      else        r_any <= |w_press_nxt;
   end
   assign any_press = r_any;
endmodule

// File: tb/tb_button_debounce_bank.sv
// tb_button_debounce_bank: directed checks of debounce latency, bounce rejection, pulses and reset, plus random pin edges.
module tb_button_debounce_bank;
   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic [3:0] btn_raw = 4'b0000;
   logic [3:0] btn_level, btn_press, btn_release;
   logic       any_press;
   int         n_chk = 0;
   int         n_fail = 0;
   logic       mon_en = 1'b0;
   logic       prev_ok = 1'b0;
   logic [3:0] prev_lvl = 4'b0000;
   always #5 CLK = ~CLK;
   button_debounce_bank #(
      .N_CH(4), .DEBOUNCE_CYC(8), .CNT_W(4), .ACTIVE_LOW(1)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .btn_raw(btn_raw), .btn_level(btn_level),
      .btn_press(btn_press), .btn_release(btn_release), .any_press(any_press)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   task automatic step(input int n = 1);
      repeat (n) @(posedge CLK);
      #1;
   endtask
   // pulses must coincide exactly with a level change; any_press is the OR of the press bits
   always @(negedge CLK) begin
      if (mon_en) begin
         chk("no_x", 32'($isunknown({btn_level, btn_press, btn_release, any_press})), 0);
         if (prev_ok) begin
            chk("press_rule", 32'(btn_press), 32'(btn_level & ~prev_lvl));
            chk("release_rule", 32'(btn_release), 32'(~btn_level & prev_lvl));
            chk("any_rule", 32'(any_press), 32'(|btn_press));
         end
         prev_lvl = btn_level;
         prev_ok  = 1'b1;
      end else prev_ok = 1'b0;
   end
   initial begin
      int   acc;
      logic bad;
      step(3);
      chk("rst_level", 32'(btn_level), 0);
      chk("rst_pulses", 32'({btn_press, btn_release, any_press}), 0);
      RST_N = 1'b1;
      step(9);
      chk("held_early", 32'(btn_level), 0);
      step();
      chk("held_level", 32'(btn_level), 32'hF);
      chk("held_press", 32'(btn_press), 32'hF);
      chk("held_any", 32'(any_press), 1);
      chk("held_rel", 32'(btn_release), 0);
      step();
      chk("held_press_end", 32'({btn_press, any_press}), 0);
      btn_raw = 4'b1111;
      step(9);
      chk("relall_early", 32'(btn_level), 32'hF);
      step();
      chk("relall_rel", 32'(btn_release), 32'hF);
      chk("relall_level", 32'(btn_level), 0);
      step(12);
      btn_raw = 4'b1110;
      step(9);
      chk("clean_early", 32'(btn_level), 0);
      step();
      chk("clean_level", 32'(btn_level), 32'h1);
      chk("clean_press", 32'(btn_press), 32'h1);
      chk("clean_rel", 32'(btn_release), 0);
      step();
      chk("clean_press_end", 32'(btn_press), 0);
      chk("clean_hold", 32'(btn_level), 32'h1);
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         btn_raw[1] = i[0];
         repeat (3) begin
            step();
            bad = bad | btn_level[1] | btn_press[1];
         end
      end
      chk("bounce_quiet", 32'(bad), 0);
      btn_raw[1] = 1'b0;
      step(9);
      chk("bounce_early", 32'(btn_level[1]), 0);
      step();
      chk("bounce_level", 32'(btn_level[1]), 1);
      chk("bounce_press", 32'(btn_press[1]), 1);
      acc = 0;
      repeat (20) begin
         step();
         acc += int'(btn_press[1]);
      end
      chk("bounce_one_pulse", 32'(acc), 0);
      btn_raw[2] = 1'b0;
      step(12);
      chk("rel_held", 32'(btn_level[2]), 1);
      btn_raw[2] = 1'b1;
      step(9);
      chk("rel_early", 32'(btn_level[2]), 1);
      step();
      chk("rel_level", 32'(btn_level[2]), 0);
      chk("rel_pulse", 32'(btn_release), 32'h4);
      chk("rel_no_press", 32'(btn_press), 0);
      step();
      chk("rel_pulse_end", 32'(btn_release), 0);
      btn_raw = 4'b1111;
      step(12);
      chk("sim_idle", 32'(btn_level), 0);
      btn_raw = 4'b0110;
      step(9);
      chk("sim_early", 32'(btn_press), 0);
      step();
      chk("sim_press", 32'(btn_press), 32'h9);
      chk("sim_any", 32'(any_press), 1);
      chk("sim_level", 32'(btn_level), 32'h9);
      step();
      chk("sim_end", 32'({btn_press, any_press}), 0);
      btn_raw = 4'b0111;
      step(12);
      chk("mid_pre", 32'(btn_level), 32'h8);
      btn_raw = 4'b0110;
      step(5);
      chk("mid_counting", 32'(btn_level), 32'h8);
      #2 RST_N = 1'b0;
      #1;
      chk("mid_rst_level", 32'(btn_level), 0);
      chk("mid_rst_pulses", 32'({btn_press, btn_release, any_press}), 0);
      step(2);
      RST_N = 1'b1;
      acc = 0;
      repeat (9) begin
         step();
         acc += int'(|{btn_press, btn_release, any_press});
      end
      chk("mid_no_pulse", 32'(acc), 0);
      step();
      chk("mid_held_press", 32'(btn_press), 32'h9);
      chk("mid_no_release", 32'(btn_release), 0);
      step(2);
      mon_en = 1'b1;
      for (int n = 0; n < 300; n++) begin
         int j;
         #($urandom_range(1, 120));
         j = $urandom_range(0, 3);
         btn_raw[j] = ~btn_raw[j];
      end
      step(30);
      mon_en = 1'b0;
      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
